// File: rtl/uart_pkg.sv
// Shared UART types, control bundle and baud divider helper.
// Used by both the transmit and receive halves.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    TX_MARK,
    TX_SPACE,
    TX_BIT
  } tx_mux_t;

  typedef struct packed {
    logic    load;
    logic    shift;
    logic    clr_clk;
    logic    clr_bit;
    tx_mux_t set_tx_mux;
  } tx_ctrl_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/tx_datapath.sv
// UART transmit datapath: shift register, bit timers, line register.
// Driven purely by the control bundle decoded in uart_tx.
module tx_datapath
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  tx_ctrl_t              ctrl,
  output logic                  tx,
  output logic                  bit_done,
  output logic                  last_bit
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         clk_count;
  logic [BW-1:0]         bit_count;
  logic                  tx_nx;

  assign bit_done = (clk_count == CLK_LAST);
  assign last_bit = (bit_count == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_count <= '0;
    end else if (ctrl.clr_clk || bit_done) begin
      clk_count <= '0;
    end else begin
      clk_count <= clk_count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_count <= '0;
    end else if (ctrl.clr_bit) begin
      bit_count <= '0;
    end else if (ctrl.shift) begin
      bit_count <= bit_count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (ctrl.load) begin
      shift_reg <= tx_data;
    end else if (ctrl.shift) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  always_comb begin
    tx_nx = 1'b1;
    unique case (ctrl.set_tx_mux)
      TX_SPACE: tx_nx = 1'b0;
      TX_BIT:   tx_nx = shift_reg[0];
      default:  tx_nx = 1'b1;
    endcase
  end

  // Line is registered so it never glitches; this adds the one-clock lead-in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_nx;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start/data/stop frame out.
// FSM and control decode here; timing and shifting in tx_datapath.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 2 || DATA_WIDTH < 1) begin : g_bad_cfg
      $error("uart_tx: CLKS_PER_BIT must be >= 2 and DATA_WIDTH >= 1");
    end
  endgenerate

  tx_state_t state;
  tx_state_t state_nx;
  tx_ctrl_t  ctrl;
  logic      bit_done;
  logic      last_bit;

  assign tx_ready = (state == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    ctrl            = '0;
    ctrl.set_tx_mux = TX_MARK;
    tx_done         = 1'b0;
    unique case (state)
      IDLE: begin
        ctrl.clr_clk = 1'b1;
        if (tx_valid) begin
          ctrl.load    = 1'b1;
          ctrl.clr_bit = 1'b1;
          state_nx     = START;
        end
      end
      START: begin
        ctrl.set_tx_mux = TX_SPACE;
        if (bit_done) begin
          ctrl.clr_bit = 1'b1;
          state_nx     = DATA;
        end
      end
      DATA: begin
        ctrl.set_tx_mux = TX_BIT;
        if (bit_done) begin
          ctrl.shift = 1'b1;
          if (last_bit) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        ctrl.set_tx_mux = TX_MARK;
        if (bit_done) begin
          tx_done  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  tx_datapath #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_dp (
    .clock   (clock),
    .reset   (reset),
    .tx_data (tx_data),
    .ctrl    (ctrl),
    .tx      (tx),
    .bit_done(bit_done),
    .last_bit(last_bit)
  );

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one parallel word per valid/ready handshake and shifts it out on `tx` as a standard 8N1-style frame (start bit, DATA_WIDTH data bits LSB first, one stop bit). It is the transmit half of the UART and pairs with `uart_rx` on the same baud/format parameters. It sits between a producer (CPU/FIFO) on the parallel side and the serial pin.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- DATA_WIDTH, 8: data bits per frame.
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_WIDTH  word to send; sampled only at handshake.
- tx_valid  input  1  producer has a word on `tx_data`.
- tx_ready  output  1  transmitter can accept a word (high only in IDLE).
- tx  output  1  serial line, idle high; registered.
- tx_done  output  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- Derived constant CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer floor). Elaboration fails if CLKS_PER_BIT < 2 or DATA_WIDTH < 1.
- The FSM has four states: IDLE, START, DATA, and STOP.
- IDLE: `tx`=1, `tx_ready`=1. If `tx_valid`&&`tx_ready`, latch `tx_data` into the shift register, clear the counters, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit_count=0.
- DATA: `tx`=shift_reg[0] for CLKS_PER_BIT cycles per bit. At each bit boundary, shift right and increment bit_count. After bit DATA_WIDTH-1, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `tx_done`=1 on the final cycle, then go to IDLE.
- `tx_valid` is ignored outside IDLE. Changes to `tx_data` after the handshake do not affect the frame in flight.
- clk_count width is $clog2(CLKS_PER_BIT) and it wraps at CLKS_PER_BIT-1. bit_count width is max(1,$clog2(DATA_WIDTH)).

## Timing
- Reset values: state=IDLE, `tx`=1, `tx_ready`=1, `tx_done`=0, counters=0, shift_reg=0.
- Reset asserted mid-frame forces `tx`=1 immediately (asynchronous) and aborts the frame. No `tx_done` is produced.
- `tx_ready` is a combinational decode of state==IDLE.
- Handshake at edge N puts `tx` low from edge N+1. This is the first-bit latency of one clock.
- A frame occupies exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles with `tx` driven by START/DATA/STOP.
- Back-to-back: `tx_ready` rises the cycle after `tx_done`. With `tx_valid` held high, the frame period is (DATA_WIDTH+2)*CLKS_PER_BIT+1 cycles, with one extra idle-high clock between frames.
- A valid already high when reset deasserts is accepted on the first clock edge after deassertion.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
  - `tx_ctrl_t` struct of control points (load, shift, clr_clk, clr_bit, set_tx_mux).
  - A function computing CLKS_PER_BIT. `uart_rx` uses the same function so both halves agree.
- Top `uart_tx` holds the FSM and control-point decode.
- One sub-module `tx_datapath` holds shift_reg, clk_count, bit_count, the `tx` output register, and the bit_done/last_bit status outputs.

## Test plan
Use CLK_FREQ=40, BAUD_RATE=10 (CLKS_PER_BIT=4), DATA_WIDTH=8.
- **Single frame:** send 0xA5. `tx` = 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then 1 for 4 clocks. `tx_done` pulses at cycle 40 after the handshake. `tx_ready` is low for 40 cycles.
- **Back-to-back:** `tx_valid` held high with 0x00 then 0xFF. The second start bit begins 41 cycles after the first. Exactly one idle-high clock separates the frames. The line decodes to 0x00, 0xFF.
- **Ignored valid/data:** pulse `tx_valid` with 0x3C mid-frame and toggle `tx_data` mid-frame. The frame in flight is unchanged, and 0x3C is not transmitted.
- **Reset mid-frame:** assert `reset` during DATA bit 3. `tx`=1 asynchronously and `tx_ready`=1. No `tx_done` is produced. The next handshake sends a clean full frame.
- **Loopback:** connect `tx` to `uart_rx` with matching params and OVERSAMPLE=2 (CLK_FREQ=40). Send 0x55, 0x81, 0xFE. `rx_valid` pulses three times with identical data.
